shift_stage: RTL

SHIFT_STAGE -- requirements
Module: shift_stage

---
 rtl/shift_stage_pkg.sv | 29 ++
 rtl/barrel_shifter.sv | 99 +++++++++
 rtl/shift_stage.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/shift_stage_pkg.sv
// Shared widths, shift-type codes, FSM states and the captured register-shift operand bundle.
package shift_stage_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned AMT_W  = 8;
   localparam int unsigned OPC_W  = 4;

   typedef enum logic [1:0] {
      SHIFT_LSL = 2'd0,
      SHIFT_LSR = 2'd1,
      SHIFT_ASR = 2'd2,
      SHIFT_ROR = 2'd3
   } shift_type_t;

   typedef enum logic {
      IDLE      = 1'b0,
      SHIFT_REG = 1'b1
   } state_t;

   typedef struct packed {
      logic [WORD_W-1:0] rn;
      logic [WORD_W-1:0] rm;
      logic [AMT_W-1:0]  rs;
      shift_type_t       stype;
      logic              carry;
      logic [OPC_W-1:0]  opcode;
   } reg_op_t;

endpackage

// File: rtl/barrel_shifter.sv
// Combinational ARM-style barrel shifter; reg_amt selects register-amount rules (8-bit amount),
// otherwise the 5-bit immediate-amount encoding where amount 0 means LSR/ASR #32 and RRX.
module barrel_shifter
   import shift_stage_pkg::*;
(
   input  logic [WORD_W-1:0] value,
   input  logic [1:0]        stype,
   input  logic [AMT_W-1:0]  amount,
   input  logic              reg_amt,
   input  logic              carry_in,
   output logic [WORD_W-1:0] result,
   output logic              carry_out
);

   logic [4:0]          amt5;
   logic                big;
   logic                is_32;
   logic [WORD_W:0]     lsl_ext;
   logic [WORD_W:0]     lsr_ext;
   logic [WORD_W:0]     asr_ext;
   logic [2*WORD_W-1:0] ror_ext;

   assign amt5  = amount[4:0];
   assign big   = amount >= AMT_W'(WORD_W);
   assign is_32 = amount == AMT_W'(WORD_W);

   // Extra bit next to the word catches the last bit shifted out.
   assign lsl_ext = {1'b0, value} << amt5;
   assign lsr_ext = {value, 1'b0} >> amt5;
   assign asr_ext = $signed({value, 1'b0}) >>> amt5;
   assign ror_ext = {value, value} >> amt5;

   always_comb begin
      result    = value;
      carry_out = carry_in;
      if (reg_amt && (amount == '0)) begin
         result    = value;
         carry_out = carry_in;
      end else if (!reg_amt && (amt5 == '0)) begin
         case (stype)
            SHIFT_LSL: begin
               result    = value;
               carry_out = carry_in;
            end
            SHIFT_LSR: begin
               result    = '0;
               carry_out = value[WORD_W-1];
            end
            SHIFT_ASR: begin
               result    = {WORD_W{value[WORD_W-1]}};
               carry_out = value[WORD_W-1];
            end
            default: begin
               result    = {carry_in, value[WORD_W-1:1]};
               carry_out = value[0];
            end
         endcase
      end else if (!big) begin
         case (stype)
            SHIFT_LSL: begin
               result    = lsl_ext[WORD_W-1:0];
               carry_out = lsl_ext[WORD_W];
            end
            SHIFT_LSR: begin
               result    = lsr_ext[WORD_W:1];
               carry_out = lsr_ext[0];
            end
            SHIFT_ASR: begin
               result    = asr_ext[WORD_W:1];
               carry_out = asr_ext[0];
            end
            default: begin
               result    = ror_ext[WORD_W-1:0];
               carry_out = ror_ext[WORD_W-1];
            end
         endcase
      end else begin
         case (stype)
            SHIFT_LSL: begin
               result    = '0;
               carry_out = is_32 ? value[0] : 1'b0;
            end
            SHIFT_LSR: begin
               result    = '0;
               carry_out = is_32 ? value[WORD_W-1] : 1'b0;
            end
            SHIFT_ASR: begin
               result    = {WORD_W{value[WORD_W-1]}};
               carry_out = value[WORD_W-1];
            end
            default: begin
               result    = ror_ext[WORD_W-1:0];
               carry_out = ror_ext[WORD_W-1];
            end
         endcase
      end
   end

endmodule

// File: rtl/shift_stage.sv
// Operand-2 shift stage feeding the ALU through a single output register.
// Define SHIFT_STAGE_REGSHIFT_EN to enable two-cycle register-amount shifts.
module shift_stage
   import shift_stage_pkg::*;
#(
   parameter int unsigned WordWidth = WORD_W
) (
   input  logic                 in_Clock,
   input  logic                 in_Reset,
   input  logic                 in_Valid,
   output logic                 out_Ready,
   input  logic [WordWidth-1:0] in_Rn,
   input  logic [WordWidth-1:0] in_Rm,
   input  logic [7:0]           in_Rs,
   input  logic [7:0]           in_Imm8,
   input  logic [3:0]           in_Rot,
   input  logic                 in_ImmSel,
   input  logic                 in_ShiftRegSel,
   input  logic [1:0]           in_ShiftType,
   input  logic [4:0]           in_ShiftImm,
   input  logic                 in_Carry,
   input  logic [3:0]           in_Opcode,
   output logic                 out_Valid,
   input  logic                 in_AluReady,
   output logic [WordWidth-1:0] out_Rn,
   output logic [WordWidth-1:0] out_Op2,
   output logic                 out_Carry,
   output logic [3:0]           out_Opcode
);

   logic              drained;
   logic              take;
   logic              busy;
   logic              reg_shift;
   logic              load_out;
   logic [WORD_W-1:0] sh_value;
   logic [1:0]        sh_type;
   logic [AMT_W-1:0]  sh_amount;
   logic              sh_reg;
   logic              sh_cin;
   logic [WORD_W-1:0] sh_result;
   logic              sh_cout;
   logic [WORD_W-1:0] load_rn;
   logic [OPC_W-1:0]  load_opcode;

`ifdef SHIFT_STAGE_REGSHIFT_EN
   state_t  state;
   state_t  state_nxt;
   reg_op_t cap;
   logic    capture;

   always_ff @(posedge in_Clock) begin
      if (in_Reset) state <= IDLE;
      else          state <= state_nxt;
   end

   // A register-amount shift parks its operands for one cycle before the shift.
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (take && reg_shift) begin
               capture   = 1'b1;
               state_nxt = SHIFT_REG;
            end
         end
         SHIFT_REG: state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge in_Clock) begin
      if (capture) begin
         cap <= '{rn: in_Rn, rm: in_Rm, rs: in_Rs, stype: shift_type_t'(in_ShiftType),
                  carry: in_Carry, opcode: in_Opcode};
      end
   end

   assign busy      = (state == SHIFT_REG);
   assign reg_shift = in_ShiftRegSel & ~in_ImmSel;
`else
   logic unused_regshift;

   assign unused_regshift = ^{in_Rs, in_ShiftRegSel};
   assign busy            = 1'b0;
   assign reg_shift       = 1'b0;
`endif

   assign drained   = ~out_Valid | in_AluReady;
   assign out_Ready = ~busy & drained;
   assign take      = in_Valid & out_Ready;
   assign load_out  = busy | (take & ~reg_shift);

   // Shifter operand select: parked register shift, rotated immediate, or immediate-amount shift.
   always_comb begin
      sh_value    = in_Rm;
      sh_type     = in_ShiftType;
      sh_amount   = AMT_W'(in_ShiftImm);
      sh_reg      = 1'b0;
      sh_cin      = in_Carry;
      load_rn     = in_Rn;
      load_opcode = in_Opcode;
      if (in_ImmSel) begin
         sh_value  = WORD_W'(in_Imm8);
         sh_type   = SHIFT_ROR;
         sh_amount = AMT_W'({in_Rot, 1'b0});
         sh_reg    = 1'b1;
      end
`ifdef SHIFT_STAGE_REGSHIFT_EN
      if (busy) begin
         sh_value    = cap.rm;
         sh_type     = cap.stype;
         sh_amount   = cap.rs;
         sh_reg      = 1'b1;
         sh_cin      = cap.carry;
         load_rn     = cap.rn;
         load_opcode = cap.opcode;
      end
`endif
   end

   barrel_shifter u_shifter (
      .value     (sh_value),
      .stype     (sh_type),
      .amount    (sh_amount),
      .reg_amt   (sh_reg),
      .carry_in  (sh_cin),
      .result    (sh_result),
      .carry_out (sh_cout)
   );

   always_ff @(posedge in_Clock) begin
      if (in_Reset) begin
         out_Valid  <= 1'b0;
         out_Rn     <= '0;
         out_Op2    <= '0;
         out_Carry  <= 1'b0;
         out_Opcode <= '0;
      end else if (load_out) begin
         out_Valid  <= 1'b1;
         out_Rn     <= load_rn;
         out_Op2    <= sh_result;
         out_Carry  <= sh_cout;
         out_Opcode <= load_opcode;
      end else if (in_AluReady) begin
         out_Valid  <= 1'b0;
      end
   end

endmodule
